riscuin_board_io: RTL and testbench
===================================

// Module: riscuin_board_io
// PURPOSE
//  Parametrised board I/O controller for RISCuin boards: a memory-mapped GPIO port, RGB status LEDs and the MCU REQ/ACK handshake.
//  Sits between the CPU data bus and the board pins, so board tops hold only pin wiring.
//  Adds features the bare board wiring lacks: input sync, edge capture, an interrupt, LED dimming, and a managed 4-phase MCU handshake.
// PARAMETERS
//  GPIO_W       8   GPIO channel count (1..32)
//  PWM_W        8   LED duty/counter width (2..16)
//  SYNC_STAGES  2   synchroniser flops on GPIO_IN and MCU_REQ (>=2)
// PORTS
//  SYS_CLK     in   1        single system clock
//  SYS_RSTn    in   1        asynchronous, active-low reset
//  bus_req     in   1        access request; held until bus_ack
//  bus_we      in   1        1 = write, 0 = read
//  bus_addr    in   4        word address
//  bus_wdata   in   32       write data
//  bus_rdata   out  32       read data; valid while bus_ack = 1
//  bus_ack     out  1        one-cycle completion pulse
//  irq         out  1        level interrupt to the CPU
//  GPIO_OUT    out  GPIO_W   output data
//  GPIO_OE     out  GPIO_W   output enable per channel (1 = drive)
//  GPIO_IN     in   GPIO_W   asynchronous pin inputs
//  LED_R/G/B   out  1 each   active-low LEDs
//  MCU_REQ     in   1        asynchronous request from the MCU
//  MCU_ACK     out  1        acknowledge to the MCU
// BEHAVIOUR
//  Reset: all registers 0; bus_rdata=0, bus_ack=0, irq=0, GPIO_OUT=0, GPIO_OE=0, LED_R/G/B=1 (off), MCU_ACK=0. Sync chains are cleared.
//  Bus: a request is accepted when bus_req=1 and bus_ack=0. bus_ack pulses on the next cycle, with the write committed on that edge.
//   A continuously held bus_req completes one access every 2 cycles. Unmapped reads return 0; unmapped writes are ignored.
//   Register bits above GPIO_W / PWM_W read as 0.
//  Register map (word addresses):
//   0 OUT   rw         1 OE   rw        2 IN   ro (synchronised pins)
//   3 EDGE  rw1c       4 IEN  rw        5/6/7 DUTY_R/G/B  rw
//   8 MCU   bit0 PEND ro, bit1 ACK (write 1 = acknowledge), bit2 MCU_IEN rw
//  Edge capture: a 0->1 transition on synchronised IN sets the EDGE bit. A set and a W1C clear on the same cycle: set wins.
//  Input-to-EDGE latency is SYNC_STAGES+1 cycles.
//  irq = |(EDGE & IEN) | (PEND & MCU_IEN); it is registered (1 cycle after the cause).
//  MCU FSM (on synchronised MCU_REQ), 4-phase:
//   IDLE: req=1 -> PEND.
//   PEND: PEND bit=1; a CPU write of ACK=1 -> ACKED. If req drops before the ack -> IDLE (request withdrawn).
//   ACKED: MCU_ACK=1; req=0 -> IDLE, where MCU_ACK drops on the transition edge.
//   A write of ACK=1 outside PEND has no effect.
//  LEDs: a free-running PWM_W-bit counter wraps at 2^PWM_W-1 -> 0. LED_x = ~(cnt < DUTY_x).
//   DUTY=0 is always off; DUTY=max gives a (2^PWM_W-1)/2^PWM_W on-fraction.
//  Reset mid-access: any pending ack is dropped and the FSM returns to IDLE with MCU_ACK=0.
// CONFIGURATION
//  RISCUIN_BOARD_IO_PWM_EN defined: PWM dimming as described above.
//  Undefined: no counter is built. LED_x = ~(DUTY_x != 0), a static on/off level.
//   DUTY registers stay fully readable and writable in both builds.
// STRUCTURE
//  Package riscuin_io_pkg holds the register address constants (REG_OUT..REG_MCU), the MCU bit indices, and the MCU FSM state encoding (IDLE/PEND/ACKED).
//  One sub-module, riscuin_sync (an SYNC_STAGES-deep, W-wide synchroniser), is instantiated for GPIO_IN and for MCU_REQ.
// TESTING
//  1. Write OUT=0xA5, OE=0x0F, then read both -> GPIO_OUT=0xA5, GPIO_OE=0x0F. Readback 0xA5/0x0F, with bus_ack exactly 1 cycle after req.
//  2. Set IEN=0x01 and raise GPIO_IN[0] -> EDGE=0x01 after SYNC_STAGES+1 cycles, irq=1 one cycle later.
//     Write EDGE=0x01 -> irq=0. A W1C on the same cycle as a new edge leaves the bit set.
//  3. Set MCU_IEN and raise MCU_REQ -> PEND=1, irq=1. Write ACK -> MCU_ACK=1.
//     Drop MCU_REQ -> MCU_ACK=0 after sync latency, state IDLE. Repeat with REQ withdrawn before ACK -> MCU_ACK stays 0.
//  4. PWM build, PWM_W=8: DUTY_R=64 -> LED_R low for 64 of every 256 cycles. DUTY_G=0 -> LED_G stays 1.
//     Non-PWM build: DUTY_R=64 -> LED_R stays 0.
//  5. Assert SYS_RSTn=0 mid-write and during ACKED -> all outputs at reset values asynchronously; the write has no effect afterwards.
//  6. Read addresses 9..15 -> 0. Writes there leave all registers unchanged.

Source files
------------

// File: rtl/riscuin_io_pkg.sv
// riscuin_io_pkg
//   Shared definitions for the RISCuin board I/O controller:
//   register word addresses, bit positions in the MCU register and the
//   MCU handshake state encoding.
package riscuin_io_pkg;

  localparam logic [3:0] REG_OUT    = 4'd0;
  localparam logic [3:0] REG_OE     = 4'd1;
  localparam logic [3:0] REG_IN     = 4'd2;
  localparam logic [3:0] REG_EDGE   = 4'd3;
  localparam logic [3:0] REG_IEN    = 4'd4;
  localparam logic [3:0] REG_DUTY_R = 4'd5;
  localparam logic [3:0] REG_DUTY_G = 4'd6;
  localparam logic [3:0] REG_DUTY_B = 4'd7;
  localparam logic [3:0] REG_MCU    = 4'd8;

  localparam int MCU_PEND_BIT = 0;
  localparam int MCU_ACK_BIT  = 1;
  localparam int MCU_IEN_BIT  = 2;

  typedef enum logic [1:0] {
    MCU_IDLE  = 2'd0,
    MCU_PEND  = 2'd1,
    MCU_ACKED = 2'd2
  } mcu_state_t;

endpackage

// File: rtl/riscuin_board_io_if.sv
// riscuin_board_io_if
//   CPU data bus seen by the board I/O controller.
//   master: CPU side, drives bus_req/bus_we/bus_addr/bus_wdata.
//   slave : controller side, drives bus_rdata/bus_ack.
interface riscuin_board_io_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/riscuin_sync.sv
// riscuin_sync
//   STAGES-deep, W-wide flop chain bringing asynchronous inputs into the
//   clk domain. Cleared by the asynchronous active-low reset.
//   Ports: clk, rst_n, d (async input), q (synchronised output).
module riscuin_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/riscuin_board_io.sv
// riscuin_board_io
//   Board I/O controller for RISCuin boards: memory-mapped GPIO with input
//   synchronisation and rising-edge capture, a level interrupt, RGB status
//   LEDs (active low) and a 4-phase MCU REQ/ACK handshake.
//   Ports: SYS_CLK/SYS_RSTn (async active-low reset), bus (slave side of the
//   CPU bus), irq, GPIO_OUT/GPIO_OE/GPIO_IN, LED_R/G/B, MCU_REQ/MCU_ACK,
//   dbg_mcu_state (current MCU handshake state, for observation).
//   Build option: RISCUIN_BOARD_IO_PWM_EN defined -> LEDs are PWM-dimmed
//   by a free-running counter; undefined -> LEDs are static on/off levels.
module riscuin_board_io
  import riscuin_io_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int PWM_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RSTn,
  riscuin_board_io_if.slave bus,
  output logic              irq,
  output logic [GPIO_W-1:0] GPIO_OUT,
  output logic [GPIO_W-1:0] GPIO_OE,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic              LED_R,
  output logic              LED_G,
  output logic              LED_B,
  input  logic              MCU_REQ,
  output logic              MCU_ACK,
  output mcu_state_t        dbg_mcu_state
);

  // Bus handshake: a request is taken on a clock edge where bus_req=1 and
  // bus_ack=0; that same edge commits a write and raises bus_ack for exactly
  // one cycle, with bus_rdata valid while bus_ack=1. Because bus_ack blocks
  // acceptance, a held bus_req completes one access every two cycles.
  logic              ack_q;
  logic [31:0]       rdata_q, rd_mux;
  logic              accept, wr, ack_wr;
  logic [GPIO_W-1:0] out_q, oe_q, ien_q, edge_q, gpio_prev, edge_clr, rise;
  logic [GPIO_W-1:0] gpio_sync;
  logic [PWM_W-1:0]  duty_r, duty_g, duty_b;
  logic              mcu_ien_q, irq_q, req_sync, mcu_pend, mcu_ack;
  mcu_state_t        state_q, state_d;
  logic              unused_wdata;

  riscuin_sync #(.W(GPIO_W), .STAGES(SYNC_STAGES)) u_sync_gpio (
    .clk(SYS_CLK), .rst_n(SYS_RSTn), .d(GPIO_IN), .q(gpio_sync)
  );

  riscuin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_req (
    .clk(SYS_CLK), .rst_n(SYS_RSTn), .d(MCU_REQ), .q(req_sync)
  );

  assign accept   = bus.bus_req & ~ack_q;
  assign wr       = accept & bus.bus_we;
  assign ack_wr   = wr && (bus.bus_addr == REG_MCU) && bus.bus_wdata[MCU_ACK_BIT];
  assign edge_clr = (wr && (bus.bus_addr == REG_EDGE)) ? bus.bus_wdata[GPIO_W-1:0] : '0;
  assign rise     = gpio_sync & ~gpio_prev;
  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign unused_wdata = ^bus.bus_wdata;

  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      REG_OUT:    rd_mux[GPIO_W-1:0] = out_q;
      REG_OE:     rd_mux[GPIO_W-1:0] = oe_q;
      REG_IN:     rd_mux[GPIO_W-1:0] = gpio_sync;
      REG_EDGE:   rd_mux[GPIO_W-1:0] = edge_q;
      REG_IEN:    rd_mux[GPIO_W-1:0] = ien_q;
      REG_DUTY_R: rd_mux[PWM_W-1:0]  = duty_r;
      REG_DUTY_G: rd_mux[PWM_W-1:0]  = duty_g;
      REG_DUTY_B: rd_mux[PWM_W-1:0]  = duty_b;
      REG_MCU: begin
        rd_mux[MCU_PEND_BIT] = mcu_pend;
        rd_mux[MCU_ACK_BIT]  = mcu_ack;
        rd_mux[MCU_IEN_BIT]  = mcu_ien_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      out_q     <= '0;
      oe_q      <= '0;
      ien_q     <= '0;
      edge_q    <= '0;
      gpio_prev <= '0;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      mcu_ien_q <= 1'b0;
    end else begin
      ack_q     <= accept;
      rdata_q   <= (accept && !bus.bus_we) ? rd_mux : '0;
      irq_q     <= (|(edge_q & ien_q)) | (mcu_pend & mcu_ien_q);
      gpio_prev <= gpio_sync;
      // OR-ing the new rises after the clear lets a same-cycle edge win.
      edge_q    <= (edge_q & ~edge_clr) | rise;
      if (wr) begin
        case (bus.bus_addr)
          REG_OUT:    out_q     <= bus.bus_wdata[GPIO_W-1:0];
          REG_OE:     oe_q      <= bus.bus_wdata[GPIO_W-1:0];
          REG_IEN:    ien_q     <= bus.bus_wdata[GPIO_W-1:0];
          REG_DUTY_R: duty_r    <= bus.bus_wdata[PWM_W-1:0];
          REG_DUTY_G: duty_g    <= bus.bus_wdata[PWM_W-1:0];
          REG_DUTY_B: duty_b    <= bus.bus_wdata[PWM_W-1:0];
          REG_MCU:    mcu_ien_q <= bus.bus_wdata[MCU_IEN_BIT];
          default:    ;
        endcase
      end
    end
  end

  // MCU handshake FSM: state register
  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) state_q <= MCU_IDLE;
    else           state_q <= state_d;
  end

  // MCU handshake FSM: next state. A request withdrawn on the same cycle as
  // the CPU ack takes priority, so the MCU never sees an ack it no longer wants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MCU_IDLE:  if (req_sync) state_d = MCU_PEND;
      MCU_PEND:  if (!req_sync) state_d = MCU_IDLE;
                 else if (ack_wr) state_d = MCU_ACKED;
      MCU_ACKED: if (!req_sync) state_d = MCU_IDLE;
      default:   state_d = MCU_IDLE;
    endcase
  end

  // MCU handshake FSM: outputs decoded from the registered state
  always_comb begin
    mcu_pend = (state_q == MCU_PEND);
    mcu_ack  = (state_q == MCU_ACKED);
  end

`ifdef RISCUIN_BOARD_IO_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) pwm_cnt <= '0;
    else           pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign LED_R = ~(pwm_cnt < duty_r);
  assign LED_G = ~(pwm_cnt < duty_g);
  assign LED_B = ~(pwm_cnt < duty_b);
`else
  assign LED_R = ~(|duty_r);
  assign LED_G = ~(|duty_g);
  assign LED_B = ~(|duty_b);
`endif

  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;
  assign irq           = irq_q;
  assign GPIO_OUT      = out_q;
  assign GPIO_OE       = oe_q;
  assign MCU_ACK       = mcu_ack;
  assign dbg_mcu_state = state_q;

endmodule

// File: tb/tb_riscuin_board_io.sv
// tb_riscuin_board_io
//   Directed bench for riscuin_board_io (default parameters). Holds a
//   register-level model of the writable registers, checks pins against it
//   on every cycle, and checks reads through an expected-value queue.
module tb_riscuin_board_io;
  import riscuin_io_pkg::*;

  localparam int GPIO_W      = 8;
  localparam int PWM_W       = 8;
  localparam int SYNC_STAGES = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              irq, led_r, led_g, led_b, mcu_req, mcu_ack;
  logic [GPIO_W-1:0] gpio_out, gpio_oe, gpio_in;
  mcu_state_t        dbg_state;
  logic [2:0]        led_v;
  assign led_v = {led_b, led_g, led_r};

  riscuin_board_io_if bus();

  riscuin_board_io #(.GPIO_W(GPIO_W), .PWM_W(PWM_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .SYS_CLK(clk), .SYS_RSTn(rst_n), .bus(bus), .irq(irq),
    .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .GPIO_IN(gpio_in),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b),
    .MCU_REQ(mcu_req), .MCU_ACK(mcu_ack), .dbg_mcu_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  logic [GPIO_W-1:0] m_out, m_oe, m_ien;
  logic [PWM_W-1:0]  m_duty[3];
  logic              m_mcu_ien;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_ien = '0; m_mcu_ien = 1'b0;
    for (int i = 0; i < 3; i++) m_duty[i] = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'd0: m_out = d[GPIO_W-1:0];
      4'd1: m_oe  = d[GPIO_W-1:0];
      4'd4: m_ien = d[GPIO_W-1:0];
      4'd5: m_duty[0] = d[PWM_W-1:0];
      4'd6: m_duty[1] = d[PWM_W-1:0];
      4'd7: m_duty[2] = d[PWM_W-1:0];
      4'd8: m_mcu_ien = d[2];
      default: ;
    endcase
  endtask

  // Per-cycle compare of pin outputs against the model.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("gpio_out", gpio_out, m_out);
      check("gpio_oe", gpio_oe, m_oe);
      if (prev_ack) check("ack_single_pulse", bus.bus_ack, 0);
      for (int i = 0; i < 3; i++) begin
`ifdef RISCUIN_BOARD_IO_PWM_EN
        if (m_duty[i] == 0) check($sformatf("led%0d_off", i), led_v[i], 1);
`else
        check($sformatf("led%0d_level", i), led_v[i], (m_duty[i] == 0));
`endif
      end
    end
    prev_ack = bus.bus_ack;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 with bus_ack low again.
  task automatic bus_txn(input logic we, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    int n = 0;
    bus.bus_req = 1'b1; bus.bus_we = we; bus.bus_addr = a; bus.bus_wdata = d;
    @(posedge clk); #1;
    check("ack_latency", bus.bus_ack, 1);
    while (!bus.bus_ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    rd = bus.bus_rdata;
    bus.bus_req = 1'b0;
    if (we && bus.bus_ack) model_write(a, d);
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_txn(1'b1, a, d, rd);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    exp_q.push_back(exp);
    bus_txn(1'b0, a, 32'h0, rd);
    check($sformatf("read_a%0d", a), rd, exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gpio_out"}, gpio_out, 0);
    check({tag, "_gpio_oe"}, gpio_oe, 0);
    check({tag, "_leds"}, led_v, 3'b111);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_ack"}, bus.bus_ack, 0);
    check({tag, "_rdata"}, bus.bus_rdata, 0);
    check({tag, "_mcu_ack"}, mcu_ack, 0);
    check({tag, "_state"}, dbg_state, MCU_IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acks;
    int low[3];
    bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
    gpio_in = '0; mcu_req = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. OUT / OE write and readback
    bus_write(REG_OUT, 32'h0000_00A5);
    check("out_pin", gpio_out, 8'hA5);
    bus_write(REG_OE, 32'h0000_000F);
    check("oe_pin", gpio_oe, 8'h0F);
    bus_read(REG_OUT, 32'h0000_00A5);
    bus_read(REG_OE, 32'h0000_000F);
    bus_write(REG_OE, 32'hFFFF_FF0F);
    bus_read(REG_OE, 32'h0000_000F);
    // held request: one access every two cycles
    acks = 0;
    bus.bus_req = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = REG_OUT;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.bus_ack) begin
        acks++;
        check("held_rdata", bus.bus_rdata, 32'hA5);
      end
    end
    bus.bus_req = 1'b0;
    check("held_ack_count", acks, 3);
    @(posedge clk); #1;

    // 2. edge capture, irq, W1C
    bus_write(REG_IEN, 32'h1);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("edge_irq_lat%0d", k), irq, (k == SYNC_STAGES + 2));
    end
    bus_read(REG_EDGE, 32'h1);
    bus_read(REG_IN, 32'h1);
    bus_write(REG_EDGE, 32'h1);
    check("irq_after_w1c", irq, 0);
    bus_read(REG_EDGE, 32'h0);
    gpio_in[1] = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 bus_write(REG_EDGE, 32'h2);  // clear lands on the same edge as the set
    bus_read(REG_EDGE, 32'h2);
    check("irq_masked", irq, 0);
    bus_write(REG_EDGE, 32'h2);
    bus_read(REG_EDGE, 32'h0);
    bus_read(REG_IN, 32'h3);
    gpio_in = '0;
    repeat (4) @(posedge clk);
    #1 bus_read(REG_EDGE, 32'h0);
    bus_write(REG_IEN, 32'h0);

    // 3. MCU handshake
    bus_write(REG_MCU, 32'h4);
    bus_read(REG_MCU, 32'h4);
    mcu_req = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("mcu_irq_lat%0d", k), irq, (k == SYNC_STAGES + 2));
    end
    check("state_pend", dbg_state, MCU_PEND);
    bus_read(REG_MCU, 32'h5);
    bus_write(REG_MCU, 32'h6);
    check("mcu_ack_high", mcu_ack, 1);
    check("state_acked", dbg_state, MCU_ACKED);
    check("irq_after_ack", irq, 0);
    bus_read(REG_MCU, 32'h6);
    mcu_req = 1'b0;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("mcu_ack_drop%0d", k), mcu_ack, (k < SYNC_STAGES + 1));
    end
    check("state_idle", dbg_state, MCU_IDLE);
    // request withdrawn before the CPU acknowledges
    mcu_req = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 check("state_pend2", dbg_state, MCU_PEND);
    mcu_req = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 check("withdraw_idle", dbg_state, MCU_IDLE);
    check("withdraw_ack", mcu_ack, 0);
    check("withdraw_irq", irq, 0);
    bus_write(REG_MCU, 32'h6);  // ack outside PEND does nothing
    check("stray_ack", mcu_ack, 0);
    check("stray_state", dbg_state, MCU_IDLE);
    bus_read(REG_MCU, 32'h4);
    bus_write(REG_MCU, 32'h0);

    // 4. LEDs
    bus_write(REG_DUTY_R, 32'd64);
    bus_write(REG_DUTY_G, 32'd0);
    bus_write(REG_DUTY_B, 32'd255);
    bus_read(REG_DUTY_R, 32'd64);
    for (int i = 0; i < 3; i++) low[i] = 0;
    for (int c = 0; c < (1 << PWM_W); c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (!led_v[i]) low[i]++;
    end
    @(posedge clk); #1;
`ifdef RISCUIN_BOARD_IO_PWM_EN
    check("led_r_low_cycles", low[0], 64);
    check("led_g_low_cycles", low[1], 0);
    check("led_b_low_cycles", low[2], 255);
`else
    check("led_r_low_cycles", low[0], 256);
    check("led_g_low_cycles", low[1], 0);
    check("led_b_low_cycles", low[2], 256);
`endif
    bus_write(REG_DUTY_G, 32'h1FF);
    bus_read(REG_DUTY_G, 32'hFF);
    bus_read(REG_DUTY_B, 32'd255);

    // 6. unmapped addresses
    for (int a = 9; a < 16; a++) bus_read(4'(a), 32'h0);
    for (int a = 9; a < 16; a++) bus_write(4'(a), 32'hFFFF_FFFF);
    bus_write(REG_IN, 32'hFFFF_FFFF);
    bus_read(REG_OUT, 32'hA5);
    bus_read(REG_OE, 32'h0F);
    bus_read(REG_IEN, 32'h0);
    bus_read(REG_EDGE, 32'h0);
    bus_read(REG_DUTY_R, 32'd64);
    bus_read(REG_MCU, 32'h0);

    // 5. reset mid-write
    bus.bus_req = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = REG_OUT; bus.bus_wdata = 32'h3C;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst_write");
    bus.bus_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out", gpio_out, 0);
    bus_read(REG_OUT, 32'h0);
    bus_read(REG_DUTY_R, 32'h0);

    // reset while ACKED
    mcu_req = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 bus_write(REG_MCU, 32'h2);
    check("pre_rst_mcu_ack", mcu_ack, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst_acked");
    mcu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 check("post_rst_state", dbg_state, MCU_IDLE);
    check("post_rst_mcu_ack", mcu_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
